// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage with valid/ready handshakes on both sides.
// Simple ops complete on the accept edge; MUL runs an iterative shift-add over DATA_W cycles.
module alu_exec_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              illegal_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] OpAnd = 4'd0;
    localparam logic [3:0] OpOr  = 4'd1;
    localparam logic [3:0] OpAdd = 4'd2;
    localparam logic [3:0] OpMul = 4'd3;
    localparam logic [3:0] OpSub = 4'd6;
    localparam logic [3:0] OpSlt = 4'd7;
    localparam logic [3:0] OpNor = 4'd12;

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                ill_q, ill_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [DATA_W-1:0]   sum, diff, simple_res;
    logic                simple_ovf, simple_ill;
    logic [2*DATA_W-1:0] acc_nxt;

    assign sum     = src1_i + src2_i;
    assign diff    = src1_i - src2_i;
    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        simple_res = '0;
        simple_ovf = 1'b0;
        simple_ill = 1'b0;
        case (ctrl_i)
            OpAnd: simple_res = src1_i & src2_i;
            OpOr:  simple_res = src1_i | src2_i;
            OpNor: simple_res = ~(src1_i | src2_i);
            OpAdd: begin
                simple_res = sum;
                simple_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                             (sum[DATA_W-1] != src1_i[DATA_W-1]);
            end
            OpSub: begin
                simple_res = diff;
                simple_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                             (diff[DATA_W-1] != src1_i[DATA_W-1]);
            end
            OpSlt: simple_res = {{(DATA_W-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            default: simple_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    if (ctrl_i == OpMul) begin
                        // Iteration 0 is folded into the load so valid_o lands in cycle DATA_W.
                        acc_d    = src2_i[0] ? {{DATA_W{1'b0}}, src1_i} : '0;
                        mcand_d  = {{(DATA_W-1){1'b0}}, src1_i, 1'b0};
                        mplier_d = src2_i >> 1;
                        cnt_d    = CntW'(1);
                        state_d  = StMul;
                    end else begin
                        result_d = simple_res;
                        ovf_d    = simple_ovf;
                        ill_d    = simple_ill;
                        zero_d   = !simple_ill && (simple_res == '0);
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    result_d = acc_nxt[DATA_W-1:0];
                    ovf_d    = |acc_nxt[2*DATA_W-1:DATA_W];
                    zero_d   = (acc_nxt[DATA_W-1:0] == '0);
                    ill_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign valid_o    = (state_q == StDone);
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign illegal_o  = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected responses,
// a monitor compares them whenever valid_o is high.
module tb_alu_exec_unit;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        i;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_o, ready_i, valid_o;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i, src2_i, result_o;
    logic        zero_o, overflow_o, illegal_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .ctrl_i     (ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o),
        .illegal_o  (illegal_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with valid_o high must match the queue head; pop on handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid actual=%h required=none", result_o);
                end else begin
                    e = exp_q[0];
                    if ({result_o, zero_o, overflow_o, illegal_o} !== {e.res, e.z, e.o, e.i}) begin
                        errors++;
                        $display("FAIL result_flags actual=%h z%b o%b i%b required=%h z%b o%b i%b",
                                 result_o, zero_o, overflow_o, illegal_o, e.res, e.z, e.o, e.i);
                    end
                    if (ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(posedge clk); #1;
        while (!ready_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) chk("ready_timeout", 64'(ready_o), 64'd1);
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int lat, input string name);
        int  n;
        logic busy_ok;
        wait_ready();
        valid_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        exp_q.push_back(e);
        @(posedge clk); #1;
        valid_i = 1'b0;
        n       = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!valid_o && n < 200) begin
            if (ready_o) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(lat));
        chk({name, "_busy"}, 64'(busy_ok), 64'd1);
        if (ready_i) begin
            @(negedge clk);
            chk({name, "_back_idle"}, {62'd0, ready_o, valid_o}, 64'b10);
        end
    endtask

    initial begin : stim
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        ctrl_i  = 4'd0;
        src1_i  = '0;
        src2_i  = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset_hs", {62'd0, ready_o, valid_o}, 64'b10);
        chk("reset_out", {29'd0, result_o, zero_o, overflow_o, illegal_o}, 64'd0);

        send(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}, 1, "add_ovf");
        send(4'd6, 32'd5, 32'd5, '{32'h0, 1'b1, 1'b0, 1'b0}, 1, "sub_zero");
        send(4'd6, 32'h8000_0000, 32'd1, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}, 1, "sub_ovf");
        send(4'd7, 32'h8000_0000, 32'h7FFF_FFFF, '{32'h1, 1'b0, 1'b0, 1'b0}, 1, "slt_neg");
        send(4'd7, 32'h0000_0001, 32'hFFFF_FFFF, '{32'h0, 1'b1, 1'b0, 1'b0}, 1, "slt_pos");
        send(4'd3, 32'd7, 32'd6, '{32'd42, 1'b0, 1'b0, 1'b0}, 32, "mul_small");
        send(4'd3, 32'h0001_0000, 32'h0001_0000, '{32'h0, 1'b1, 1'b1, 1'b0}, 32, "mul_hi");
        send(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'h1, 1'b0, 1'b1, 1'b0}, 32, "mul_max");
        send(4'd8, 32'h1234_5678, 32'h1, '{32'h0, 1'b0, 1'b0, 1'b1}, 1, "illegal8");
        send(4'd5, 32'h0, 32'h0, '{32'h0, 1'b0, 1'b0, 1'b1}, 1, "illegal5");
        send(4'd12, 32'h0, 32'h0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}, 1, "nor");

        // Backpressure: result held while ready_i low, and a pending request waits for IDLE.
        ready_i = 1'b0;
        send(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hF000_F000, 1'b0, 1'b0, 1'b0}, 1, "and_bp");
        @(posedge clk); #1;
        valid_i = 1'b1;
        ctrl_i  = 4'd1;
        src1_i  = 32'h0000_000F;
        src2_i  = 32'h0000_00F0;
        exp_q.push_back('{32'h0000_00FF, 1'b0, 1'b0, 1'b0});
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold", {62'd0, valid_o, ready_o}, 64'b10);
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_no_accept", {62'd0, valid_o, ready_o}, 64'b01);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("accept_after_drain", 64'(valid_o), 64'd1);

        // Reset in the middle of a multiply.
        wait_ready();
        valid_i = 1'b1;
        ctrl_i  = 4'd3;
        src1_i  = 32'h0000_FFFF;
        src2_i  = 32'h0000_FFFF;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("midmul_reset_hs", {62'd0, ready_o, valid_o}, 64'b10);
        chk("midmul_reset_out", {29'd0, result_o, zero_o, overflow_o, illegal_o}, 64'd0);
        send(4'd2, 32'd1, 32'd2, '{32'd3, 1'b0, 1'b0, 1'b0}, 1, "add_after_reset");

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
